// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory block-copy engine: default widths and FSM state encoding.
package mem_copy_pkg;

    localparam int unsigned DEF_WORD     = 16;
    localparam int unsigned DEF_ADDRESSL = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_ptr.sv
// Loadable address pointer; counts up by one and wraps modulo 2**ADDRESSL.
module mem_copy_ptr
    import mem_copy_pkg::*;
#(
    parameter int unsigned ADDRESSL = DEF_ADDRESSL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                inc,
    input  logic [ADDRESSL-1:0] load_value,
    output logic [ADDRESSL-1:0] value
);

    // Load has priority over increment; natural overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= value + ADDRESSL'(1);
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Block-copy memory master: copies `length` words src -> dst, ascending, one read and one write per word.
// Optional feature: define MEM_COPY_CHECKSUM_EN to accumulate a running sum of copied words on `checksum`.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned WORD     = DEF_WORD,
    parameter int unsigned ADDRESSL = DEF_ADDRESSL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDRESSL-1:0] src_addr,
    input  logic [ADDRESSL-1:0] dst_addr,
    input  logic [ADDRESSL:0]   length,
    output logic                busy,
    output logic                done,
    output logic [WORD-1:0]     checksum,
    output logic [ADDRESSL-1:0] mem_address,
    output logic [WORD-1:0]     mem_write_data,
    input  logic [WORD-1:0]     mem_read_data,
    output logic                mem_read,
    output logic                mem_write
);

    localparam int unsigned LENW = ADDRESSL + 1;

    state_t              state;
    logic [LENW-1:0]     remaining;
    logic [ADDRESSL-1:0] src_ptr;
    logic [ADDRESSL-1:0] dst_ptr;
    logic                accept;

    assign accept = (state == ST_IDLE) && start;

    mem_copy_ptr #(.ADDRESSL(ADDRESSL)) u_src_ptr (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .inc        (state == ST_READ),
        .load_value (src_addr),
        .value      (src_ptr)
    );

    mem_copy_ptr #(.ADDRESSL(ADDRESSL)) u_dst_ptr (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .inc        (state == ST_WRITE),
        .load_value (dst_addr),
        .value      (dst_ptr)
    );

    // Sequencer: state and remaining word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= length;
                        state     <= (length == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    remaining <= remaining - LENW'(1);
                    state     <= (remaining == LENW'(1)) ? ST_DONE : ST_READ;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [WORD-1:0] sum_q;

    // Running sum of words passed through in WRITE; cleared on each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (state == ST_WRITE) begin
            sum_q <= sum_q + mem_read_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    // Bus decode from state; everything is forced idle while rst is high so a reset cycle never writes.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        busy           = (state != ST_IDLE);
        done           = (state == ST_DONE);
        case (state)
            ST_READ: begin
                mem_read    = 1'b1;
                mem_address = src_ptr;
            end
            ST_WRITE: begin
                mem_write      = 1'b1;
                mem_address    = dst_ptr;
                mem_write_data = mem_read_data;
            end
            default: ;
        endcase
        if (rst) begin
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            mem_address    = '0;
            mem_write_data = '0;
            busy           = 1'b0;
            done           = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a registered-read data memory model.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  src_addr = '0;
    logic [9:0]  dst_addr = '0;
    logic [10:0] length = '0;
    logic        busy, done, mem_read, mem_write;
    logic [15:0] checksum, mem_write_data;
    logic [15:0] mem_read_data = '0;
    logic [9:0]  mem_address;

    logic [15:0] mem [0:1023];
    logic        tb_we = 1'b0;
    logic [9:0]  tb_addr = '0;
    logic [15:0] tb_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    int done_cyc, ndone, nrd, nwr, nbusy, perr;

    mem_copy_engine #(.WORD(16), .ADDRESSL(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .checksum       (checksum),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, write at the edge; bench port used only for preloading.
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_write) mem[mem_address] <= mem_write_data;
        if (mem_read) mem_read_data <= mem[mem_address];
    end

    function automatic logic [15:0] exp_ck(input logic [15:0] s);
`ifdef MEM_COPY_CHECKSUM_EN
        return s;
`else
        return 16'h0000 & s;
`endif
    endfunction

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Start a copy and watch the bus until busy falls; optional second start injected at intr_cyc.
    task automatic run_copy(input logic [9:0] src, input logic [9:0] dst, input logic [10:0] len,
                            input int intr_cyc, input logic [9:0] isrc, input logic [9:0] idst,
                            input logic [10:0] ilen);
        int budget;
        budget = 2 * int'(len) + 20;
        done_cyc = -1; ndone = 0; nrd = 0; nwr = 0; nbusy = 0; perr = 0;
        @(negedge clk);
        start = 1'b1; src_addr = src; dst_addr = dst; length = len;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (mem_read && mem_write) perr++;
            if (!mem_read && !mem_write && (mem_address !== 10'h0 || mem_write_data !== 16'h0)) perr++;
            if (mem_read) begin
                if (mem_address !== 10'(int'(src) + nrd)) perr++;
                nrd++;
            end
            if (mem_write) begin
                if (mem_address !== 10'(int'(dst) + nwr)) perr++;
                if (mem_write_data !== mem_read_data) perr++;
                nwr++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (intr_cyc != 0 && cyc == intr_cyc) begin
                start = 1'b1; src_addr = isrc; dst_addr = idst; length = ilen;
            end else if (intr_cyc != 0 && cyc == intr_cyc + 1) begin
                start = 1'b0;
            end
            if (busy) nbusy++;
            else break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); end
        n_checks++; if (mem_address !== 10'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 000", mem_address); end
        n_checks++; if (checksum !== 16'h0) begin n_fail++; $display("FAIL reset_checksum: got %h expected 0000", checksum); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        poke(10'h010, 16'h00A1); poke(10'h011, 16'h00B2);
        poke(10'h012, 16'h00C3); poke(10'h013, 16'h00D4);
        run_copy(10'h010, 10'h200, 11'd4, 0, '0, '0, '0);
        n_checks++; if (done_cyc !== 9) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 9", done_cyc); end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", ndone); end
        n_checks++; if (nbusy !== 9) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 9", nbusy); end
        n_checks++; if (nrd !== 4 || nwr !== 4) begin n_fail++; $display("FAIL basic_access_count: got rd=%0d wr=%0d expected 4/4", nrd, nwr); end
        n_checks++; if (perr !== 0) begin n_fail++; $display("FAIL basic_bus_protocol: got %0d errors expected 0", perr); end
        n_checks++; if ({mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]} !== 64'h00A1_00B2_00C3_00D4) begin
            n_fail++; $display("FAIL basic_data: got %h %h %h %h expected 00a1 00b2 00c3 00d4",
                               mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]); end
        n_checks++; if (checksum !== exp_ck(16'h02EA)) begin n_fail++; $display("FAIL basic_checksum: got %h expected %h", checksum, exp_ck(16'h02EA)); end
    endtask

    task automatic test_single_word();
        poke(10'h030, 16'h1234);
        run_copy(10'h030, 10'h230, 11'd1, 0, '0, '0, '0);
        n_checks++; if (done_cyc !== 3) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 3", done_cyc); end
        n_checks++; if (mem[10'h230] !== 16'h1234) begin n_fail++; $display("FAIL single_data: got %h expected 1234", mem[10'h230]); end
    endtask

    task automatic test_zero_length();
        run_copy(10'h010, 10'h200, 11'd0, 0, '0, '0, '0);
        n_checks++; if (done_cyc !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        n_checks++; if (nrd !== 0 || nwr !== 0) begin n_fail++; $display("FAIL zero_no_access: got rd=%0d wr=%0d expected 0/0", nrd, nwr); end
        n_checks++; if (nbusy !== 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 1", nbusy); end
        n_checks++; if (checksum !== 16'h0) begin n_fail++; $display("FAIL zero_checksum: got %h expected 0000", checksum); end
    endtask

    task automatic test_wrap();
        poke(10'h3FE, 16'd1); poke(10'h3FF, 16'd2); poke(10'h000, 16'd3); poke(10'h001, 16'd4);
        run_copy(10'h3FE, 10'h100, 11'd4, 0, '0, '0, '0);
        n_checks++; if (perr !== 0) begin n_fail++; $display("FAIL wrap_bus_protocol: got %0d errors expected 0", perr); end
        n_checks++; if ({mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]} !== 64'h0001_0002_0003_0004) begin
            n_fail++; $display("FAIL wrap_data: got %h %h %h %h expected 0001 0002 0003 0004",
                               mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]); end
        n_checks++; if (checksum !== exp_ck(16'd10)) begin n_fail++; $display("FAIL wrap_checksum: got %h expected %h", checksum, exp_ck(16'd10)); end
    endtask

    task automatic test_overlap();
        poke(10'h020, 16'd5); poke(10'h021, 16'd6); poke(10'h022, 16'd7); poke(10'h023, 16'd8);
        run_copy(10'h020, 10'h021, 11'd3, 0, '0, '0, '0);
        n_checks++; if ({mem[10'h020], mem[10'h021], mem[10'h022], mem[10'h023]} !== 64'h0005_0005_0005_0005) begin
            n_fail++; $display("FAIL overlap_data: got %h %h %h %h expected 0005 0005 0005 0005",
                               mem[10'h020], mem[10'h021], mem[10'h022], mem[10'h023]); end
        n_checks++; if (checksum !== exp_ck(16'd15)) begin n_fail++; $display("FAIL overlap_checksum: got %h expected %h", checksum, exp_ck(16'd15)); end
    endtask

    task automatic test_start_during_busy();
        int late_busy;
        poke(10'h040, 16'd11); poke(10'h041, 16'd22); poke(10'h042, 16'd33); poke(10'h043, 16'd44);
        poke(10'h250, 16'hBEEF); poke(10'h251, 16'hBEEF);
        run_copy(10'h040, 10'h240, 11'd4, 3, 10'h050, 10'h250, 11'd2);
        late_busy = 0;
        repeat (4) begin @(negedge clk); if (busy) late_busy++; end
        n_checks++; if (done_cyc !== 9 || ndone !== 1) begin n_fail++; $display("FAIL busy_start_done: got cycle %0d count %0d expected 9/1", done_cyc, ndone); end
        n_checks++; if (nwr !== 4 || perr !== 0) begin n_fail++; $display("FAIL busy_start_writes: got wr=%0d err=%0d expected 4/0", nwr, perr); end
        n_checks++; if (late_busy !== 0) begin n_fail++; $display("FAIL busy_start_not_queued: got %0d busy cycles expected 0", late_busy); end
        n_checks++; if (mem[10'h250] !== 16'hBEEF || mem[10'h243] !== 16'd44) begin
            n_fail++; $display("FAIL busy_start_data: got %h %h expected beef 002c", mem[10'h250], mem[10'h243]); end
    endtask

    task automatic test_reset_mid_op();
        int spurious;
        for (int i = 0; i < 8; i++) begin
            poke(10'(10'h080 + i), 16'(16'h0100 + i));
            poke(10'(10'h300 + i), 16'hDEAD);
        end
        @(negedge clk);
        start = 1'b1; src_addr = 10'h080; dst_addr = 10'h300; length = 11'd8;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({mem_read, mem_write, done, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_gating: got rd/wr/done/busy=%b expected 0000", {mem_read, mem_write, done, busy}); end
        @(posedge clk); #1 rst = 1'b0;
        spurious = 0;
        repeat (6) begin @(negedge clk); if (done || busy) spurious++; end
        n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL midreset_idle: got %0d busy/done cycles expected 0", spurious); end
        n_checks++; if ({mem[10'h300], mem[10'h301], mem[10'h302]} !== 48'h0100_0101_DEAD) begin
            n_fail++; $display("FAIL midreset_partial: got %h %h %h expected 0100 0101 dead", mem[10'h300], mem[10'h301], mem[10'h302]); end
        run_copy(10'h080, 10'h300, 11'd8, 0, '0, '0, '0);
        n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL midreset_recopy_done: got %0d expected 17", done_cyc); end
        n_checks++; if (mem[10'h302] !== 16'h0102 || mem[10'h307] !== 16'h0107) begin
            n_fail++; $display("FAIL midreset_recopy_data: got %h %h expected 0102 0107", mem[10'h302], mem[10'h307]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_word();
        test_zero_length();
        test_wrap();
        test_overlap();
        test_start_during_busy();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
